super_large_number_sweeper: RTL and testbench

SUPER_LARGE_NUMBER_SWEEPER -- requirements
Module: super_large_number_sweeper

---
 rtl/super_large_number_sweeper.sv | 136 +++++++++++++
 tb/tb_super_large_number_sweeper.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/super_large_number_sweeper.sv
// super_large_number_sweeper
// Walks value_o from LO up to HI, one step per accepted handshake, and counts
// how many accepted values the downstream predicate flagged with result_i.
// Optional first-hit capture: define SUPER_LARGE_NUMBER_FIRST_HIT_EN to add
// first_hit_o / first_hit_valid_o.
module super_large_number_sweeper #(
  // 7'sb1000000 is -64, the most negative 7-bit value
  parameter logic signed [6:0] LO = 7'sb1000000,
  parameter logic signed [6:0] HI = 7'sd63
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic              start_i,
  output logic signed [6:0] value_o,
  output logic              value_valid_o,
  input  logic              value_ready_i,
  input  logic              result_i,
  output logic [7:0]        count_o,
  output logic              busy_o,
  output logic              done_o
`ifdef SUPER_LARGE_NUMBER_FIRST_HIT_EN
  ,
  output logic signed [6:0] first_hit_o,
  output logic              first_hit_valid_o
`endif
);

  // An empty or inverted range cannot describe a sweep; refuse to elaborate.
  generate
    if (LO > HI) begin : g_bad_range
      $error("super_large_number_sweeper: LO must not exceed HI");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] COUNT_MAX = 8'd128;

  state_t             r_state;
  logic signed [6:0]  r_value;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic [7:0]         r_count;

  logic w_handshake;
  logic w_at_hi;

  assign w_handshake = r_valid & value_ready_i;
  // Comparing against HI before incrementing is what keeps HI from wrapping.
  assign w_at_hi     = (r_value == HI);

  // Sweep FSM with all visible outputs held in registers.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state <= S_IDLE;
      r_value <= LO;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_state <= S_RUN;
            r_value <= LO;
            r_count <= 8'd0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_handshake) begin
            if (result_i && (r_count != COUNT_MAX)) begin
              r_count <= r_count + 8'd1;
            end
            if (w_at_hi) begin
              // Last value accepted: value_o parks on HI
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_value <= r_value + 7'sd1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign value_o       = r_value;
  assign value_valid_o = r_valid;
  assign count_o       = r_count;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

`ifdef SUPER_LARGE_NUMBER_FIRST_HIT_EN
  logic signed [6:0] r_first_hit;
  logic              r_first_hit_valid;

  // Capture the first accepted value that the predicate flagged.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_first_hit       <= 7'sd0;
      r_first_hit_valid <= 1'b0;
    end else if ((r_state == S_IDLE) && start_i) begin
      r_first_hit       <= 7'sd0;
      r_first_hit_valid <= 1'b0;
    end else if ((r_state == S_RUN) && w_handshake && result_i && !r_first_hit_valid) begin
      r_first_hit       <= r_value;
      r_first_hit_valid <= 1'b1;
    end
  end

  assign first_hit_o       = r_first_hit;
  assign first_hit_valid_o = r_first_hit_valid;
`endif

endmodule

// File: tb/tb_super_large_number_sweeper.sv
// Directed bench for super_large_number_sweeper: table of full sweeps plus
// hand sequences for reset mid-sweep, held start, and a two-value range.
module tb_super_large_number_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic              start;
  logic              ready;
  logic              result;
  logic signed [6:0] value;
  logic              valid;
  logic [7:0]        count;
  logic              busy;
  logic              done;
  int                mode;

  logic              s_start;
  logic              s_one;
  logic signed [6:0] s_value;
  logic              s_valid;
  logic [7:0]        s_count;
  logic              s_busy;
  logic              s_done;

`ifdef SUPER_LARGE_NUMBER_FIRST_HIT_EN
  logic signed [6:0] fh;
  logic              fh_valid;
  logic signed [6:0] s_fh;
  logic              s_fh_valid;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Predicate model: combinational on the presented value
  always_comb begin
    case (mode)
      0:       result = 1'b1;
      1:       result = (value > 7'sd0);
      2:       result = 1'b0;
      3:       result = (value < 7'sd0);
      default: result = 1'b0;
    endcase
  end

  super_large_number_sweeper u_dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .start_i         (start),
    .value_o         (value),
    .value_valid_o   (valid),
    .value_ready_i   (ready),
    .result_i        (result),
    .count_o         (count),
    .busy_o          (busy),
    .done_o          (done)
`ifdef SUPER_LARGE_NUMBER_FIRST_HIT_EN
    ,
    .first_hit_o       (fh),
    .first_hit_valid_o (fh_valid)
`endif
  );

  super_large_number_sweeper #(.LO(7'sd62), .HI(7'sd63)) u_small (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .start_i         (s_start),
    .value_o         (s_value),
    .value_valid_o   (s_valid),
    .value_ready_i   (s_one),
    .result_i        (s_one),
    .count_o         (s_count),
    .busy_o          (s_busy),
    .done_o          (s_done)
`ifdef SUPER_LARGE_NUMBER_FIRST_HIT_EN
    ,
    .first_hit_o       (s_fh),
    .first_hit_valid_o (s_fh_valid)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One full sweep on the default-range DUT. Starts at a negedge, returns at
  // the negedge after the done pulse (FSM back in IDLE).
  task automatic run_sweep(input int rdy_toggle, input int exp_count, input int exp_run,
                           input int exp_fh_valid, input int exp_fh, input bit keep_start);
    int exp_val;
    int run;
    int hs;
    int vbad;
    int stray;
    bit seen_done;
    exp_val   = -64;
    run       = 0;
    hs        = 0;
    vbad      = 0;
    stray     = 0;
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    for (int cyc = 0; cyc < 600 && !seen_done; cyc++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (valid) begin
          ready = (rdy_toggle != 0 && (run % 2) == 1) ? 1'b0 : 1'b1;
          run++;
          if (int'(value) != exp_val) vbad++;
          if (busy != 1'b1) stray++;
          if (ready) begin
            exp_val++;
            hs++;
          end
        end else begin
          ready = 1'b0;
          stray++;
        end
        @(negedge clk);
      end
    end
    chk("done_seen", int'(seen_done), 1);
    chk("run_cycles", run, exp_run);
    chk("handshakes", hs, 128);
    chk("value_seq_errors", vbad, 0);
    chk("run_flag_errors", stray, 0);
    chk("count_at_done", int'(count), exp_count);
    chk("value_at_done", int'(value), 63);
    chk("valid_at_done", int'(valid), 0);
`ifdef SUPER_LARGE_NUMBER_FIRST_HIT_EN
    chk("fh_valid", int'(fh_valid), exp_fh_valid);
    if (exp_fh_valid != 0) chk("fh_value", int'(fh), exp_fh);
`endif
    ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("count_held", int'(count), exp_count);
  endtask

  typedef struct {
    int mode;
    int rdy_toggle;
    int exp_count;
    int exp_run;
    int exp_fh_valid;
    int exp_fh;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  reached;
    int  bad_after;
    bit  seen;

    vecs[0] = '{0, 0, 128, 128, 1, -64};
    vecs[1] = '{1, 0,  63, 128, 1,   1};
    vecs[2] = '{2, 0,   0, 128, 0,   0};
    vecs[3] = '{3, 0,  64, 128, 1, -64};
    vecs[4] = '{0, 1, 128, 255, 1, -64};
    vecs[5] = '{1, 1,  63, 255, 1,   1};

    rstn    = 1'b0;
    start   = 1'b0;
    ready   = 1'b0;
    mode    = 0;
    s_start = 1'b0;
    s_one   = 1'b1;

    // Reset state, during and right after reset
    @(negedge clk);
    chk("rst_value", int'(value), -64);
    chk("rst_valid", int'(valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_value", int'(value), -64);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_valid", int'(valid), 0);
    $display("reset: value=%0d count=%0d busy=%0d", value, count, busy);

    // Table-driven full sweeps
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      run_sweep(vecs[i].rdy_toggle, vecs[i].exp_count, vecs[i].exp_run,
                vecs[i].exp_fh_valid, vecs[i].exp_fh, 1'b0);
      $display("sweep %0d: mode=%0d toggle=%0d count=%0d", i, vecs[i].mode,
               vecs[i].rdy_toggle, count);
    end

    // Reset asserted mid-sweep at value 10
    mode    = 0;
    reached = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && reached == 0; cyc++) begin
      if (valid && value == 7'sd10) begin
        reached = 1;
      end else begin
        ready = 1'b1;
        @(negedge clk);
      end
    end
    chk("reached_10", reached, 1);
    chk("count_before_abort", int'(count), 74);
    #2 rstn = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_count", int'(count), 0);
    chk("abort_value", int'(value), -64);
    chk("abort_done", int'(done), 0);
    ready = 1'b0;
    @(negedge clk);
    rstn      = 1'b1;
    bad_after = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (busy || done || valid) bad_after++;
    end
    chk("no_restart_without_start", bad_after, 0);
    $display("reset at value 10: count=%0d busy=%0d", count, busy);
    run_sweep(0, 128, 128, 1, -64, 1'b0);
    $display("restart sweep: count=%0d", count);

    // start held through the whole sweep: one sweep, then a second begins
    run_sweep(0, 128, 128, 1, -64, 1'b1);
    @(negedge clk);
    chk("held_start_rerun_busy", int'(busy), 1);
    chk("held_start_rerun_value", int'(value), -64);
    chk("held_start_rerun_count", int'(count), 0);
    start = 1'b0;
    seen  = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      ready = 1'b1;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("held_start_second_done", int'(seen), 1);
    chk("held_start_second_count", int'(count), 128);
    ready = 1'b0;
    @(negedge clk);
    $display("held start: second sweep count=%0d", count);

    // Two-value range LO=62 HI=63: no wrap past 63
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("small_v0_valid", int'(s_valid), 1);
    chk("small_v0", int'(s_value), 62);
    @(negedge clk);
    chk("small_v1_valid", int'(s_valid), 1);
    chk("small_v1", int'(s_value), 63);
    chk("small_v1_count", int'(s_count), 1);
    @(negedge clk);
    chk("small_done", int'(s_done), 1);
    chk("small_hold_hi", int'(s_value), 63);
    chk("small_count", int'(s_count), 2);
    chk("small_valid_off", int'(s_valid), 0);
`ifdef SUPER_LARGE_NUMBER_FIRST_HIT_EN
    chk("small_fh", int'(s_fh), 62);
    chk("small_fh_valid", int'(s_fh_valid), 1);
`endif
    @(negedge clk);
    chk("small_done_pulse", int'(s_done), 0);
    chk("small_no_wrap", int'(s_value), 63);
    chk("small_busy_off", int'(s_busy), 0);
    $display("small range: value=%0d count=%0d", s_value, s_count);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
